// File: rtl/ad7528_pkg.sv
// Shared types for the AD7528 serial DAC writer.
// Command bundle, FSM state encoding and frame length.
package ad7528_pkg;

    typedef struct packed {
        logic       chip;
        logic       dac_sel;
        logic [7:0] value;
    } ad7528_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } ad7528_wr_state_e;

    localparam int AD7528_FRAME_BITS = 9;

    function automatic logic [AD7528_FRAME_BITS-1:0] frame_bits(
        input ad7528_cmd_t c
    );
        return {c.dac_sel, c.value};
    endfunction

endpackage

// File: rtl/ad7528_cmd_fifo.sv
// Synchronous command FIFO in front of the AD7528 writer FSM.
// DEPTH must be a power of two, at least 2.
module ad7528_cmd_fifo
    import ad7528_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  ad7528_cmd_t wdata,
    input  logic        pop,
    output ad7528_cmd_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end

    ad7528_cmd_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset, pointers gate validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ad7528_serial_writer.sv
// Serial writer for the dual AD7528 attenuation DACs (MSB-first, 9-bit frame).
// Optional command queue enabled by defining AD7528_WRITER_QUEUE_EN.
module ad7528_serial_writer
    import ad7528_pkg::*;
#(
    parameter int CLK_DIV     = 15,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_chip,
    input  logic       cmd_dac_sel,
    input  logic [7:0] cmd_value,
    output logic       busy,
    output logic       datadac,
    output logic       clkdac,
    output logic       csdac1n,
    output logic       csdac2n
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be >= 1");
    end

    if (QUEUE_DEPTH < 1) begin : g_bad_qd
        $error("QUEUE_DEPTH must be >= 1");
    end

    ad7528_wr_state_e state;
    ad7528_wr_state_e state_next;
    logic [CW-1:0]    cnt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_idx;
    ad7528_cmd_t      cmd_q;
    ad7528_cmd_t      in_cmd;
    ad7528_cmd_t      start_cmd;
    logic [AD7528_FRAME_BITS-1:0] frame;
    logic             phase_end;
    logic             start;
    logic             fifo_empty;

    assign in_cmd    = '{chip: cmd_chip, dac_sel: cmd_dac_sel, value: cmd_value};
    assign frame     = frame_bits(cmd_q);
    assign phase_end = (cnt == '0);

`ifdef AD7528_WRITER_QUEUE_EN
    logic fifo_full;
    logic fifo_pop;

    // Pop when idle, or on the last GAP cycle so frames run back to back.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || (state == GAP && phase_end));
    assign start     = fifo_pop;
    assign cmd_ready = !fifo_full;

    ad7528_cmd_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk30),
        .reset (reset),
        .push  (cmd_valid && !fifo_full),
        .wdata (in_cmd),
        .pop   (fifo_pop),
        .rdata (start_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    assign fifo_empty = 1'b1;
    assign cmd_ready  = (state == IDLE);
    assign start      = cmd_valid && cmd_ready;
    assign start_cmd  = in_cmd;
`endif

    assign busy = (state != IDLE) || !fifo_empty;

    // State, phase timer, bit counter and latched command.
    always_ff @(posedge clk30) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            cmd_q   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) cnt <= RELOAD;
            else if (cnt != '0)      cnt <= cnt - 1'b1;
            if (start) begin
                cmd_q   <= start_cmd;
                bit_cnt <= 4'(AD7528_FRAME_BITS - 1);
            end else if (state == LOW && phase_end && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Next-state and bus outputs; LOW already shows the following bit.
    always_comb begin
        state_next = state;
        datadac    = 1'b0;
        clkdac     = 1'b0;
        csdac1n    = 1'b1;
        csdac2n    = 1'b1;
        bit_idx    = bit_cnt;
        unique case (state)
            IDLE: begin
                if (start) state_next = SETUP;
            end
            SETUP: begin
                csdac1n = cmd_q.chip;
                csdac2n = !cmd_q.chip;
                datadac = frame[bit_idx];
                if (phase_end) state_next = HIGH;
            end
            HIGH: begin
                csdac1n = cmd_q.chip;
                csdac2n = !cmd_q.chip;
                clkdac  = 1'b1;
                datadac = frame[bit_idx];
                if (phase_end) state_next = LOW;
            end
            LOW: begin
                csdac1n = cmd_q.chip;
                csdac2n = !cmd_q.chip;
                if (bit_cnt != '0) bit_idx = bit_cnt - 1'b1;
                datadac = frame[bit_idx];
                if (phase_end) state_next = (bit_cnt == '0) ? GAP : HIGH;
            end
            GAP: begin
                if (phase_end) state_next = start ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad7528_serial_writer.sv
// Directed self-checking bench for ad7528_serial_writer.
// Covers base build and AD7528_WRITER_QUEUE_EN build.
module tb_ad7528_serial_writer;

`ifdef AD7528_WRITER_QUEUE_EN
    localparam int D = 2;
`else
    localparam int D = 15;
`endif
    localparam int RST_AT = (100 * D) / 15;

    logic       clk30 = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_chip = 1'b0;
    logic       cmd_dac_sel = 1'b0;
    logic [7:0] cmd_value = 8'h00;
    logic       cmd_ready;
    logic       busy;
    logic       datadac;
    logic       clkdac;
    logic       csdac1n;
    logic       csdac2n;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_acc = 0;
    logic mon_clk = 1'b0;
    logic mon_d = 1'b0;

    ad7528_serial_writer #(
        .CLK_DIV     (D),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk30       (clk30),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chip    (cmd_chip),
        .cmd_dac_sel (cmd_dac_sel),
        .cmd_value   (cmd_value),
        .busy        (busy),
        .datadac     (datadac),
        .clkdac      (clkdac),
        .csdac1n     (csdac1n),
        .csdac2n     (csdac2n)
    );

    always #5 clk30 = ~clk30;

    // Cycle counter and accepted-command counter.
    always @(posedge clk30) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One negedge step plus the bus protocol monitor.
    task automatic tick();
        @(negedge clk30);
        chk("one_cs", 32'(!csdac1n && !csdac2n), 32'd0);
        if (csdac1n && csdac2n) chk("clk_idle", 32'(clkdac), 32'd0);
        if (clkdac && mon_clk) chk("data_stable", 32'(datadac), 32'(mon_d));
        mon_clk = clkdac;
        mon_d   = datadac;
    endtask

    task automatic push(input logic chip, input logic sel,
                        input logic [7:0] val, output int acc);
        int n;
        n = 0;
        cmd_chip    = chip;
        cmd_dac_sel = sel;
        cmd_value   = val;
        cmd_valid   = 1'b1;
        while (!cmd_ready && n < 50 * D + 100) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk30);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
        tick();
    endtask

    task automatic frame_chk(input logic chip, input logic sel,
                             input logic [7:0] val, output int idle);
        logic       prev;
        logic       got_chip;
        logic [8:0] bits;
        int         nb;
        int         low;
        prev = 1'b0;
        bits = '0;
        nb   = 0;
        low  = 0;
        idle = 0;
        while (csdac1n && csdac2n && idle < 100 * D + 100) begin
            idle++;
            tick();
        end
        got_chip = csdac1n;
        while ((!csdac1n || !csdac2n) && low < 40 * D) begin
            low++;
            if (clkdac && !prev) begin
                bits = {bits[7:0], datadac};
                nb++;
            end
            prev = clkdac;
            tick();
        end
        chk("frame_chip", 32'(got_chip), 32'(chip));
        chk("frame_bits", 32'(bits), 32'({sel, val}));
        chk("frame_nedges", 32'(nb), 32'd9);
        chk("cs_low_len", 32'(low), 32'(19 * D));
    endtask

    int acc;
    int idle;
    int a0;
    int n;
    logic [9:0] qcmd [4];

    initial begin
        repeat (3) tick();
        chk("reset_state",
            32'({datadac, clkdac, csdac1n, csdac2n, busy, cmd_ready}),
            32'(6'b001101));
        reset = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("idle_hold",
                32'({datadac, clkdac, csdac1n, csdac2n, busy, cmd_ready}),
                32'(6'b001101));
        end

        push(1'b0, 1'b0, 8'hA5, acc);
        chk("busy_run", 32'(busy), 32'd1);
        frame_chk(1'b0, 1'b0, 8'hA5, idle);
        chk("setup_latency", 32'(idle), 32'd0);
`ifndef AD7528_WRITER_QUEUE_EN
        n = 0;
        while (!cmd_ready && n < 40 * D) begin
            tick();
            n++;
        end
        chk("ready_latency", 32'(cyc - acc + 1), 32'(20 * D + 1));
        chk("idle_after", 32'(busy), 32'd0);

        push(1'b1, 1'b1, 8'h00, acc);
        a0 = n_acc;
        chk("ready_low_busy", 32'(cmd_ready), 32'd0);
        cmd_chip    = 1'b0;
        cmd_dac_sel = 1'b0;
        cmd_value   = 8'h3C;
        cmd_valid   = 1'b1;
        frame_chk(1'b1, 1'b1, 8'h00, idle);
        chk("held_not_taken", 32'(n_acc - a0), 32'd0);
        n = 0;
        while (!cmd_ready && n < 40 * D) begin
            tick();
            n++;
        end
        @(posedge clk30);
        #1;
        cmd_valid = 1'b0;
        tick();
        chk("held_taken", 32'(n_acc - a0), 32'd1);
        frame_chk(1'b0, 1'b0, 8'h3C, idle);
        repeat (2 * D + 2) tick();
        chk("no_duplicate", 32'(n_acc - a0), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
`else
        repeat (2 * D + 2) tick();
        push(1'b1, 1'b1, 8'h00, acc);
        push(1'b0, 1'b0, 8'h3C, acc);
        frame_chk(1'b1, 1'b1, 8'h00, idle);
        frame_chk(1'b0, 1'b0, 8'h3C, idle);
        chk("gap_len", 32'(idle), 32'(D));
        repeat (2 * D + 2) tick();
        chk("busy_done", 32'(busy), 32'd0);
`endif

        push(1'b0, 1'b1, 8'h5A, acc);
        repeat (RST_AT - 1) tick();
        reset = 1'b1;
        @(posedge clk30);
        #1;
        chk("reset_mid",
            32'({csdac1n, csdac2n, clkdac, busy, cmd_ready}),
            32'(5'b11001));
        reset = 1'b0;
        tick();
        push(1'b1, 1'b0, 8'hC3, acc);
        frame_chk(1'b1, 1'b0, 8'hC3, idle);
        chk("post_reset_start", 32'(idle), 32'd0);
        repeat (2 * D + 2) tick();

`ifdef AD7528_WRITER_QUEUE_EN
        qcmd[0] = {1'b1, 1'b0, 8'h81};
        qcmd[1] = {1'b0, 1'b1, 8'h7E};
        qcmd[2] = {1'b1, 1'b1, 8'hF0};
        qcmd[3] = {1'b0, 1'b0, 8'h0F};
        push(1'b0, 1'b0, 8'h11, acc);
        tick();
        chk("preload_run", 32'(!csdac1n), 32'd1);
        a0 = n_acc;
        for (int i = 0; i < 4; i++)
            push(qcmd[i][9], qcmd[i][8], qcmd[i][7:0], acc);
        chk("four_taken", 32'(n_acc - a0), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        cmd_value = 8'h99;
        cmd_valid = 1'b1;
        @(posedge clk30);
        #1;
        cmd_valid = 1'b0;
        tick();
        chk("fifth_rejected", 32'(n_acc - a0), 32'd4);
        n = 0;
        while ((!csdac1n || !csdac2n) && n < 40 * D) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            frame_chk(qcmd[i][9], qcmd[i][8], qcmd[i][7:0], idle);
            chk("queue_gap", 32'(idle), 32'(D));
        end
        repeat (2 * D + 2) tick();
        chk("queue_drained", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
